// File: rtl/tcpc_reg_bank.sv
// TCPCI register bank: host REQ/ACK byte access, ALERT with W1C and masking,
// RX message capture buffer, TX payload buffer, COMMAND/TRANSMIT strobes.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for REQ; address/direction/data latched on REQ=1
// S_ACCESS | read mux sampled into RD_DATA or write committed
// S_DONE   | ACK held high until the host drops REQ
module tcpc_reg_bank #(
    parameter int          ADDR_W    = 8,
    parameter int          DATA_W    = 8,
    parameter int          BUF_BYTES = 30,
    parameter logic [15:0] VID       = 16'h0000,
    parameter logic [15:0] PID       = 16'h0000,
    parameter logic [15:0] DID       = 16'h0000
) (
    input  logic                         CLK,
    input  logic                         RESET_N,
    input  logic [ADDR_W-1:0]            ADDR,
    input  logic                         RNW,
    input  logic [DATA_W-1:0]            WR_DATA,
    output logic [DATA_W-1:0]            RD_DATA,
    input  logic                         REQ,
    output logic                         ACK,
    input  logic [15:0]                  ALERT_SET,
    input  logic                         RX_WR_EN,
    input  logic [7:0]                   RX_WR_DATA,
    input  logic                         RX_MSG_DONE,
    input  logic [2:0]                   RX_FRAME_TYPE,
    input  logic [$clog2(BUF_BYTES)-1:0] TX_RD_ADDR,
    output logic [7:0]                   TX_RD_DATA,
    output logic                         TX_START,
    output logic [7:0]                   TX_CTRL,
    output logic                         CMD_VALID,
    output logic [7:0]                   CMD,
    output logic                         ALERT_N
);

    localparam int IDX_W = $clog2(BUF_BYTES);
    localparam int PTR_W = $clog2(BUF_BYTES + 1);

    localparam logic [ADDR_W-1:0] A_VID_L     = ADDR_W'(8'h00);
    localparam logic [ADDR_W-1:0] A_VID_H     = ADDR_W'(8'h01);
    localparam logic [ADDR_W-1:0] A_PID_L     = ADDR_W'(8'h02);
    localparam logic [ADDR_W-1:0] A_PID_H     = ADDR_W'(8'h03);
    localparam logic [ADDR_W-1:0] A_DID_L     = ADDR_W'(8'h04);
    localparam logic [ADDR_W-1:0] A_DID_H     = ADDR_W'(8'h05);
    localparam logic [ADDR_W-1:0] A_ALERT_L   = ADDR_W'(8'h10);
    localparam logic [ADDR_W-1:0] A_ALERT_H   = ADDR_W'(8'h11);
    localparam logic [ADDR_W-1:0] A_MASK_L    = ADDR_W'(8'h12);
    localparam logic [ADDR_W-1:0] A_MASK_H    = ADDR_W'(8'h13);
    localparam logic [ADDR_W-1:0] A_TCPC_CTRL = ADDR_W'(8'h19);
    localparam logic [ADDR_W-1:0] A_ROLE_CTRL = ADDR_W'(8'h1A);
    localparam logic [ADDR_W-1:0] A_COMMAND   = ADDR_W'(8'h23);
    localparam logic [ADDR_W-1:0] A_RX_DET    = ADDR_W'(8'h2F);
    localparam logic [ADDR_W-1:0] A_RX_CNT    = ADDR_W'(8'h30);
    localparam logic [ADDR_W-1:0] A_RX_TYPE   = ADDR_W'(8'h31);
    localparam logic [ADDR_W-1:0] A_RX_BUF    = ADDR_W'(8'h32);
    localparam logic [ADDR_W-1:0] A_TRANSMIT  = ADDR_W'(8'h50);
    localparam logic [ADDR_W-1:0] A_TX_CNT    = ADDR_W'(8'h51);
    localparam logic [ADDR_W-1:0] A_TX_BUF    = ADDR_W'(8'h52);

    localparam logic [ADDR_W-1:0] BUF_A   = ADDR_W'(BUF_BYTES);
    localparam logic [PTR_W-1:0]  PTR_MAX = PTR_W'(BUF_BYTES);
    localparam logic [IDX_W:0]    TX_LIM  = (IDX_W + 1)'(BUF_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                rnw_q, rnw_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic                ack_q, ack_d;
    logic [15:0]         alert_q, alert_d;
    logic [15:0]         mask_q, mask_d;
    logic                alert_n_q, alert_n_d;
    logic [7:0]          tcpc_ctrl_q, tcpc_ctrl_d;
    logic [7:0]          role_ctrl_q, role_ctrl_d;
    logic [7:0]          rx_det_q, rx_det_d;
    logic [7:0]          rx_count_q, rx_count_d;
    logic [2:0]          frame_q, frame_d;
    logic [PTR_W-1:0]    rx_ptr_q, rx_ptr_d;
    logic [7:0]          tx_ctrl_q, tx_ctrl_d;
    logic [7:0]          tx_count_q, tx_count_d;
    logic [7:0]          cmd_q, cmd_d;
    logic                tx_start_q, tx_start_d;
    logic                cmd_valid_q, cmd_valid_d;
    logic [7:0]          rx_buf_q [BUF_BYTES];
    logic [7:0]          rx_buf_d [BUF_BYTES];
    logic [7:0]          tx_buf_q [BUF_BYTES];
    logic [7:0]          tx_buf_d [BUF_BYTES];

    logic                acc_wr, acc_rd;
    logic [ADDR_W-1:0]   rx_off, tx_off;
    logic                in_rx, in_tx;
    logic [IDX_W-1:0]    rx_idx, tx_idx;
    logic [7:0]          rd_byte, wb;
    logic [15:0]         w1c, rx_set;
    logic [PTR_W-1:0]    ptr_n;

    // Handshake sequencing; request fields captured only when leaving IDLE.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        rnw_d     = rnw_q;
        wr_data_d = wr_data_q;
        case (state_q)
            S_IDLE: begin
                if (REQ) begin
                    state_d   = S_ACCESS;
                    addr_d    = ADDR;
                    rnw_d     = RNW;
                    wr_data_d = WR_DATA;
                end
            end
            S_ACCESS: state_d = S_DONE;
            S_DONE:   if (!REQ) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
        ack_d = (state_d == S_DONE);
    end

    // Address decode and read mux over the latched address.
    always_comb begin
        acc_wr  = (state_q == S_ACCESS) && !rnw_q;
        acc_rd  = (state_q == S_ACCESS) && rnw_q;
        rx_off  = addr_q - A_RX_BUF;
        tx_off  = addr_q - A_TX_BUF;
        in_rx   = (addr_q >= A_RX_BUF) && (rx_off < BUF_A);
        in_tx   = (addr_q >= A_TX_BUF) && (tx_off < BUF_A);
        rx_idx  = rx_off[IDX_W-1:0];
        tx_idx  = tx_off[IDX_W-1:0];
        rd_byte = 8'h00;
        case (addr_q)
            A_VID_L:     rd_byte = VID[7:0];
            A_VID_H:     rd_byte = VID[15:8];
            A_PID_L:     rd_byte = PID[7:0];
            A_PID_H:     rd_byte = PID[15:8];
            A_DID_L:     rd_byte = DID[7:0];
            A_DID_H:     rd_byte = DID[15:8];
            A_ALERT_L:   rd_byte = alert_q[7:0];
            A_ALERT_H:   rd_byte = alert_q[15:8];
            A_MASK_L:    rd_byte = mask_q[7:0];
            A_MASK_H:    rd_byte = mask_q[15:8];
            A_TCPC_CTRL: rd_byte = tcpc_ctrl_q;
            A_ROLE_CTRL: rd_byte = role_ctrl_q;
            A_RX_DET:    rd_byte = rx_det_q;
            A_RX_CNT:    rd_byte = rx_count_q;
            A_RX_TYPE:   rd_byte = {5'b0, frame_q};
            A_TRANSMIT:  rd_byte = tx_ctrl_q;
            A_TX_CNT:    rd_byte = tx_count_q;
            default: begin
                if (in_rx)      rd_byte = rx_buf_q[rx_idx];
                else if (in_tx) rd_byte = tx_buf_q[tx_idx];
            end
        endcase
    end

    // Host writes, RX capture and ALERT update; hardware set beats host clear.
    always_comb begin
        wb          = wr_data_q[7:0];
        rd_data_d   = rd_data_q;
        mask_d      = mask_q;
        tcpc_ctrl_d = tcpc_ctrl_q;
        role_ctrl_d = role_ctrl_q;
        rx_det_d    = rx_det_q;
        rx_count_d  = rx_count_q;
        frame_d     = frame_q;
        tx_ctrl_d   = tx_ctrl_q;
        tx_count_d  = tx_count_q;
        cmd_d       = cmd_q;
        tx_start_d  = 1'b0;
        cmd_valid_d = 1'b0;
        rx_buf_d    = rx_buf_q;
        tx_buf_d    = tx_buf_q;
        w1c         = 16'h0000;
        rx_set      = 16'h0000;

        if (acc_rd) rd_data_d = DATA_W'(rd_byte);

        if (acc_wr) begin
            case (addr_q)
                A_ALERT_L:   w1c[7:0]    = wb;
                A_ALERT_H:   w1c[15:8]   = wb;
                A_MASK_L:    mask_d[7:0] = wb;
                A_MASK_H:    mask_d[15:8] = wb;
                A_TCPC_CTRL: tcpc_ctrl_d = wb;
                A_ROLE_CTRL: role_ctrl_d = wb;
                A_RX_DET:    rx_det_d    = wb;
                A_COMMAND: begin
                    cmd_d       = wb;
                    cmd_valid_d = 1'b1;
                end
                A_TRANSMIT: begin
                    tx_ctrl_d  = wb;
                    tx_start_d = 1'b1;
                end
                A_TX_CNT:    tx_count_d  = wb;
                default:     if (in_tx) tx_buf_d[tx_idx] = wb;
            endcase
        end

        // A pending message (ALERT[2]) or a full buffer turns new bytes into overflow.
        ptr_n = rx_ptr_q;
        if (RX_WR_EN) begin
            if (alert_q[2] || (rx_ptr_q == PTR_MAX)) begin
                rx_set[10] = 1'b1;
            end else begin
                rx_buf_d[rx_ptr_q[IDX_W-1:0]] = RX_WR_DATA;
                ptr_n = rx_ptr_q + 1'b1;
            end
        end
        rx_ptr_d = ptr_n;

        if (w1c[2]) rx_count_d = 8'h00;
        if (RX_MSG_DONE && !alert_q[2]) begin
            rx_count_d = 8'(ptr_n) + 8'd1;
            frame_d    = RX_FRAME_TYPE;
            rx_set[2]  = 1'b1;
            rx_ptr_d   = '0;
        end

        alert_d   = (alert_q & ~w1c) | ALERT_SET | rx_set;
        alert_n_d = ~|(alert_q & mask_q);
    end

    // State and register storage.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rnw_q       <= 1'b0;
            wr_data_q   <= '0;
            rd_data_q   <= '0;
            ack_q       <= 1'b0;
            alert_q     <= 16'h0000;
            mask_q      <= 16'h7FFF;
            alert_n_q   <= 1'b1;
            tcpc_ctrl_q <= 8'h00;
            role_ctrl_q <= 8'h00;
            rx_det_q    <= 8'h00;
            rx_count_q  <= 8'h00;
            frame_q     <= 3'd0;
            rx_ptr_q    <= '0;
            tx_ctrl_q   <= 8'h00;
            tx_count_q  <= 8'h00;
            cmd_q       <= 8'h00;
            tx_start_q  <= 1'b0;
            cmd_valid_q <= 1'b0;
            for (int i = 0; i < BUF_BYTES; i++) begin
                rx_buf_q[i] <= 8'h00;
                tx_buf_q[i] <= 8'h00;
            end
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            rnw_q       <= rnw_d;
            wr_data_q   <= wr_data_d;
            rd_data_q   <= rd_data_d;
            ack_q       <= ack_d;
            alert_q     <= alert_d;
            mask_q      <= mask_d;
            alert_n_q   <= alert_n_d;
            tcpc_ctrl_q <= tcpc_ctrl_d;
            role_ctrl_q <= role_ctrl_d;
            rx_det_q    <= rx_det_d;
            rx_count_q  <= rx_count_d;
            frame_q     <= frame_d;
            rx_ptr_q    <= rx_ptr_d;
            tx_ctrl_q   <= tx_ctrl_d;
            tx_count_q  <= tx_count_d;
            cmd_q       <= cmd_d;
            tx_start_q  <= tx_start_d;
            cmd_valid_q <= cmd_valid_d;
            rx_buf_q    <= rx_buf_d;
            tx_buf_q    <= tx_buf_d;
        end
    end

    assign RD_DATA    = rd_data_q;
    assign ACK        = ack_q;
    assign TX_START   = tx_start_q;
    assign TX_CTRL    = tx_ctrl_q;
    assign CMD_VALID  = cmd_valid_q;
    assign CMD        = cmd_q;
    assign ALERT_N    = alert_n_q;
    assign TX_RD_DATA = ({1'b0, TX_RD_ADDR} < TX_LIM) ? tx_buf_q[TX_RD_ADDR] : 8'h00;

endmodule

// File: tb/tb_tcpc_reg_bank.sv
// Directed bench for tcpc_reg_bank: ID reads, ALERT W1C/mask, RX capture and
// overflow, TX buffer and strobes, mid-access reset.
module tb_tcpc_reg_bank;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [7:0]  ADDR;
    logic        RNW;
    logic [7:0]  WR_DATA;
    logic [7:0]  RD_DATA;
    logic        REQ;
    logic        ACK;
    logic [15:0] ALERT_SET;
    logic        RX_WR_EN;
    logic [7:0]  RX_WR_DATA;
    logic        RX_MSG_DONE;
    logic [2:0]  RX_FRAME_TYPE;
    logic [4:0]  TX_RD_ADDR;
    logic [7:0]  TX_RD_DATA;
    logic        TX_START;
    logic [7:0]  TX_CTRL;
    logic        CMD_VALID;
    logic [7:0]  CMD;
    logic        ALERT_N;

    int total = 0;
    int bad   = 0;
    int tx_start_cnt = 0;
    int cmd_valid_cnt = 0;
    logic [7:0] tx_ctrl_seen = 8'h00;
    logic [7:0] cmd_seen = 8'h00;

    tcpc_reg_bank #(
        .ADDR_W(8), .DATA_W(8), .BUF_BYTES(30),
        .VID(16'h1234), .PID(16'h5678), .DID(16'h9ABC)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .ADDR(ADDR), .RNW(RNW), .WR_DATA(WR_DATA),
        .RD_DATA(RD_DATA), .REQ(REQ), .ACK(ACK), .ALERT_SET(ALERT_SET),
        .RX_WR_EN(RX_WR_EN), .RX_WR_DATA(RX_WR_DATA), .RX_MSG_DONE(RX_MSG_DONE),
        .RX_FRAME_TYPE(RX_FRAME_TYPE), .TX_RD_ADDR(TX_RD_ADDR), .TX_RD_DATA(TX_RD_DATA),
        .TX_START(TX_START), .TX_CTRL(TX_CTRL), .CMD_VALID(CMD_VALID), .CMD(CMD),
        .ALERT_N(ALERT_N)
    );

    always #5 CLK = ~CLK;

    // Strobe monitor: counts cycles the pulses are high and the value beside them.
    always @(negedge CLK) begin
        if (TX_START === 1'b1) begin
            tx_start_cnt <= tx_start_cnt + 1;
            tx_ctrl_seen <= TX_CTRL;
        end
        if (CMD_VALID === 1'b1) begin
            cmd_valid_cnt <= cmd_valid_cnt + 1;
            cmd_seen      <= CMD;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic access(input logic [7:0] a, input logic rnw, input logic [7:0] wd,
                          output logic [7:0] rd);
        int n;
        @(negedge CLK);
        ADDR = a; RNW = rnw; WR_DATA = wd; REQ = 1'b1;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (ACK !== 1'b1 && n < 8);
        check($sformatf("ack_lat_%02h", a), n, 2);
        rd = RD_DATA;
        REQ = 1'b0;
        @(negedge CLK);
        check($sformatf("ack_drop_%02h", a), {31'b0, ACK}, 0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        logic [7:0] dummy;
        access(a, 1'b0, d, dummy);
    endtask

    task automatic rd_chk(input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] v;
        access(a, 1'b1, 8'h00, v);
        check($sformatf("rd_%02h", a), {24'b0, v}, {24'b0, exp});
    endtask

    task automatic rx_push(input logic [7:0] d);
        @(negedge CLK);
        RX_WR_EN = 1'b1; RX_WR_DATA = d;
        @(negedge CLK);
        RX_WR_EN = 1'b0;
    endtask

    task automatic rx_done(input logic [2:0] ft);
        @(negedge CLK);
        RX_MSG_DONE = 1'b1; RX_FRAME_TYPE = ft;
        @(negedge CLK);
        RX_MSG_DONE = 1'b0;
    endtask

    task automatic alert_pulse(input logic [15:0] s);
        @(negedge CLK);
        ALERT_SET = s;
        @(negedge CLK);
        ALERT_SET = 16'h0000;
        @(negedge CLK);
    endtask

    logic [7:0] id_exp [6];
    int s0;

    initial begin
        id_exp[0] = 8'h34; id_exp[1] = 8'h12; id_exp[2] = 8'h78;
        id_exp[3] = 8'h56; id_exp[4] = 8'hBC; id_exp[5] = 8'h9A;

        RESET_N = 1'b0; ADDR = 8'h00; RNW = 1'b1; WR_DATA = 8'h00; REQ = 1'b0;
        ALERT_SET = 16'h0000; RX_WR_EN = 1'b0; RX_WR_DATA = 8'h00;
        RX_MSG_DONE = 1'b0; RX_FRAME_TYPE = 3'd0; TX_RD_ADDR = 5'd0;
        repeat (3) @(negedge CLK);
        check("rst_ack", {31'b0, ACK}, 0);
        check("rst_rd_data", {24'b0, RD_DATA}, 0);
        check("rst_alert_n", {31'b0, ALERT_N}, 1);
        check("rst_tx_start", {31'b0, TX_START}, 0);
        check("rst_cmd_valid", {31'b0, CMD_VALID}, 0);
        check("rst_cmd", {24'b0, CMD}, 0);
        check("rst_tx_ctrl", {24'b0, TX_CTRL}, 0);
        RESET_N = 1'b1;

        for (int i = 0; i < 6; i++) rd_chk(8'(i), id_exp[i]);
        rd_chk(8'h10, 8'h00);
        rd_chk(8'h12, 8'hFF);
        rd_chk(8'h13, 8'h7F);
        rd_chk(8'h30, 8'h00);

        // ALERT set, W1C and masking
        alert_pulse(16'h0004);
        check("alert_n_set", {31'b0, ALERT_N}, 0);
        rd_chk(8'h10, 8'h04);
        wr(8'h10, 8'h04);
        check("alert_n_clr", {31'b0, ALERT_N}, 1);
        rd_chk(8'h10, 8'h00);
        wr(8'h12, 8'h00);
        alert_pulse(16'h0004);
        @(negedge CLK);
        check("alert_n_masked", {31'b0, ALERT_N}, 1);
        wr(8'h12, 8'hFF);
        check("alert_n_unmask", {31'b0, ALERT_N}, 0);
        wr(8'h10, 8'h04);
        check("alert_n_clr2", {31'b0, ALERT_N}, 1);

        // Hardware set lands on the same edge as the W1C commit
        @(negedge CLK);
        ADDR = 8'h10; RNW = 1'b0; WR_DATA = 8'h04; REQ = 1'b1;
        @(negedge CLK);
        ALERT_SET = 16'h0004;
        @(negedge CLK);
        ALERT_SET = 16'h0000;
        check("same_cyc_ack", {31'b0, ACK}, 1);
        REQ = 1'b0;
        @(negedge CLK);
        rd_chk(8'h10, 8'h04);
        wr(8'h10, 8'h04);
        rd_chk(8'h10, 8'h00);

        // RX message capture
        for (int i = 0; i < 5; i++) rx_push(8'hAA + 8'(i * 8'h11));
        rx_done(3'd3);
        rd_chk(8'h30, 8'h06);
        rd_chk(8'h31, 8'h03);
        for (int i = 0; i < 5; i++) rd_chk(8'h32 + 8'(i), 8'hAA + 8'(i * 8'h11));
        rd_chk(8'h10, 8'h04);
        check("alert_n_rx", {31'b0, ALERT_N}, 0);

        // Pending message: byte dropped, overflow flagged, second done ignored
        rx_push(8'h55);
        rx_done(3'd5);
        rd_chk(8'h11, 8'h04);
        rd_chk(8'h32, 8'hAA);
        rd_chk(8'h30, 8'h06);
        rd_chk(8'h31, 8'h03);
        wr(8'h10, 8'h04);
        wr(8'h11, 8'h04);
        rd_chk(8'h30, 8'h00);
        rd_chk(8'h11, 8'h00);

        // Buffer saturation at BUF_BYTES
        for (int i = 0; i < 32; i++) rx_push(8'h40 + 8'(i));
        rd_chk(8'h11, 8'h04);
        rx_done(3'd1);
        rd_chk(8'h30, 8'd31);
        rd_chk(8'h32, 8'h40);
        rd_chk(8'h4F, 8'h5D);
        rd_chk(8'h50, 8'h00);
        wr(8'h10, 8'h04);
        wr(8'h11, 8'h04);

        // Byte and message-done in the same cycle
        rx_push(8'h21);
        @(negedge CLK);
        RX_WR_EN = 1'b1; RX_WR_DATA = 8'h22; RX_MSG_DONE = 1'b1; RX_FRAME_TYPE = 3'd2;
        @(negedge CLK);
        RX_WR_EN = 1'b0; RX_MSG_DONE = 1'b0;
        rd_chk(8'h30, 8'h03);
        rd_chk(8'h31, 8'h02);
        rd_chk(8'h33, 8'h22);
        wr(8'h10, 8'h04);

        // TX buffer, TRANSMIT and COMMAND strobes
        wr(8'h52, 8'h11);
        wr(8'h53, 8'h22);
        wr(8'h6F, 8'h99);
        s0 = tx_start_cnt;
        wr(8'h50, 8'h01);
        repeat (2) @(negedge CLK);
        check("tx_start_pulses", tx_start_cnt - s0, 1);
        check("tx_ctrl_at_start", {24'b0, tx_ctrl_seen}, 32'h01);
        check("tx_ctrl", {24'b0, TX_CTRL}, 32'h01);
        check("tx_start_idle", {31'b0, TX_START}, 0);
        TX_RD_ADDR = 5'd1;  #1 check("tx_rd_1", {24'b0, TX_RD_DATA}, 32'h22);
        TX_RD_ADDR = 5'd0;  #1 check("tx_rd_0", {24'b0, TX_RD_DATA}, 32'h11);
        TX_RD_ADDR = 5'd29; #1 check("tx_rd_29", {24'b0, TX_RD_DATA}, 32'h99);
        TX_RD_ADDR = 5'd30; #1 check("tx_rd_30", {24'b0, TX_RD_DATA}, 32'h00);
        TX_RD_ADDR = 5'd31; #1 check("tx_rd_31", {24'b0, TX_RD_DATA}, 32'h00);
        rd_chk(8'h50, 8'h01);
        rd_chk(8'h53, 8'h22);
        s0 = cmd_valid_cnt;
        wr(8'h23, 8'h77);
        repeat (2) @(negedge CLK);
        check("cmd_valid_pulses", cmd_valid_cnt - s0, 1);
        check("cmd_at_valid", {24'b0, cmd_seen}, 32'h77);
        check("cmd", {24'b0, CMD}, 32'h77);
        rd_chk(8'h23, 8'h00);
        wr(8'h00, 8'h55);
        rd_chk(8'h00, 8'h34);
        wr(8'h19, 8'h5A);
        rd_chk(8'h19, 8'h5A);
        wr(8'h2F, 8'h21);
        rd_chk(8'h2F, 8'h21);

        // Reset while a write to ALERT_MASK is in ACCESS
        @(negedge CLK);
        ADDR = 8'h12; RNW = 1'b0; WR_DATA = 8'h00; REQ = 1'b1;
        @(negedge CLK);
        RESET_N = 1'b0; REQ = 1'b0;
        #1 check("mid_rst_ack", {31'b0, ACK}, 0);
        @(negedge CLK);
        RESET_N = 1'b1;
        check("mid_rst_cmd", {24'b0, CMD}, 0);
        check("mid_rst_alert_n", {31'b0, ALERT_N}, 1);
        rd_chk(8'h12, 8'hFF);
        rd_chk(8'h13, 8'h7F);
        rd_chk(8'hFF, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tcpc_reg_bank.md
Name: tcpc_reg_bank

Overview:
Clocked, parametrised TCPCI register bank for the USB-PD port controller. Gives the host side a REQ/ACK byte-access interface. Gives the PHY/protocol side these hardware ports: RX message fill, TX buffer read, ALERT set inputs, command/transmit strobes and an active-low interrupt. Adds over the previous register block: a clock, the handshake FSM, write-1-to-clear ALERT with masking, and RX/TX buffers whose depth is set by a parameter.

Parameters:
ADDR_W, 8, host address width
DATA_W, 8, host data width (register bytes)
BUF_BYTES, 30, RX/TX payload buffer depth in bytes (header 2 + 7 objects x 4)
VID, 16'h0000, VENDOR_ID read-only value
PID, 16'h0000, PRODUCT_ID read-only value
DID, 16'h0000, DEVICE_ID read-only value

Ports:
CLK  in  1  clock, all logic on rising edge
RESET_N  in  1  asynchronous active-low reset
ADDR  in  ADDR_W  host register address
RNW  in  1  1=read, 0=write
WR_DATA  in  DATA_W  host write data
RD_DATA  out  DATA_W  host read data, valid while ACK=1
REQ  in  1  host request, held high until ACK seen
ACK  out  1  access complete
ALERT_SET  in  16  hardware alert set strobes, one per ALERT bit
RX_WR_EN  in  1  append RX_WR_DATA to RX buffer
RX_WR_DATA  in  8  received byte
RX_MSG_DONE  in  1  received message complete
RX_FRAME_TYPE  in  3  SOP type of the completed message
TX_RD_ADDR  in  $clog2(BUF_BYTES)  TX buffer read index
TX_RD_DATA  out  8  TX buffer byte, combinational from TX_RD_ADDR
TX_START  out  1  one-cycle pulse on a host write to TRANSMIT
TX_CTRL  out  8  TRANSMIT register contents
CMD_VALID  out  1  one-cycle pulse on a host write to COMMAND
CMD  out  8  last written COMMAND byte
ALERT_N  out  1  low while (ALERT & ALERT_MASK) != 0

Behaviour:
- Reset values: RD_DATA=0, ACK=0, TX_START=0, CMD_VALID=0, CMD=0, TX_CTRL=0, ALERT=0, ALERT_MASK=16'h7FFF, RX pointer=0, RECEIVE_BYTE_COUNT=0. ALERT_N=1.
- Address map (byte-wide):
  - 0x00-0x05: VID/PID/DID, little-endian, read-only.
  - 0x10-0x11: ALERT, W1C.
  - 0x12-0x13: ALERT_MASK, R/W.
  - 0x19: TCPC_CONTROL, R/W.
  - 0x1A: ROLE_CONTROL, R/W.
  - 0x23: COMMAND, write-only, reads 0.
  - 0x2F: RECEIVE_DETECT, R/W.
  - 0x30: RECEIVE_BYTE_COUNT, read-only.
  - 0x31: RX_BUF_FRAME_TYPE, read-only.
  - 0x32 to 0x32+BUF_BYTES-1: RX buffer, read-only.
  - 0x50: TRANSMIT, R/W.
  - 0x51: TRANSMIT_BYTE_COUNT, R/W.
  - 0x52 to 0x52+BUF_BYTES-1: TX buffer, R/W.
  - Unmapped addresses: reads return 0, writes are ignored, ACK is still returned.
- Handshake FSM: IDLE -> ACCESS -> DONE.
  - IDLE: on REQ=1, latch ADDR/RNW/WR_DATA and go to ACCESS.
  - ACCESS: perform the read or write, register RD_DATA, go to DONE.
  - DONE: ACK=1. Return to IDLE with ACK=0 on the first cycle REQ=0.
  - Latency: ACK rises 2 cycles after REQ is sampled high.
  - No new access starts until REQ has dropped. RD_DATA holds its value until the next read.
  - A write to an address that is not writable during ACCESS has no effect.
- ALERT bits:
  - Hardware set: bit i sets when ALERT_SET[i]=1.
  - Host clear: writing 1 to bit i clears it.
  - Same-cycle set and clear: set wins.
  - ALERT_N is registered, 1-cycle latency from the ALERT/ALERT_MASK change.
- RX path:
  - RX_WR_EN writes the byte at the pointer, then pointer+1.
  - RX_MSG_DONE: RECEIVE_BYTE_COUNT = pointer + 1, RX_BUF_FRAME_TYPE = RX_FRAME_TYPE, set ALERT[2], reset pointer to 0.
  - While ALERT[2]=1, RX_WR_EN bytes are dropped and ALERT[10] (RX overflow) sets. A further RX_MSG_DONE is ignored.
  - When pointer == BUF_BYTES, further bytes are dropped, ALERT[10] sets, and the pointer saturates.
  - RX_WR_EN and RX_MSG_DONE in the same cycle: the byte is stored first, then the count includes it.
  - Host clear of ALERT[2] also clears RECEIVE_BYTE_COUNT to 0.
- TX path:
  - A host write to TRANSMIT updates TX_CTRL and pulses TX_START in the ACCESS cycle.
  - TX_RD_ADDR >= BUF_BYTES gives TX_RD_DATA = 0.
- A host write to COMMAND updates CMD and pulses CMD_VALID in the ACCESS cycle.
- Reset asserted mid-access: immediate return to IDLE with reset values. No partial write is committed.

Test Plan:
- Read 0x00-0x05 with VID=16'h1234, PID=16'h5678, DID=16'h9ABC -> RD_DATA 34,12,78,56,BC,9A. ACK 2 cycles after REQ; ACK drops 1 cycle after REQ drops.
- ALERT_SET[2] pulse with mask 7FFF -> ALERT_N=0 next cycle. Write 0x10=0x04 -> ALERT=0, ALERT_N=1. Same-cycle ALERT_SET[2] and W1C -> bit stays 1.
- 5 RX_WR_EN bytes AA..EE then RX_MSG_DONE, frame type 3 -> 0x30 reads 6, 0x31 reads 3, 0x32-0x36 read AA..EE, ALERT[2]=1.
- With ALERT[2]=1, push 1 byte -> byte dropped, ALERT[10]=1. After clearing ALERT[2], push BUF_BYTES+2 bytes -> pointer saturates at 30, ALERT[10]=1.
- Write TX buffer 0x52=0x11, 0x53=0x22, then 0x50=0x01 -> TX_START one-cycle pulse, TX_CTRL=01, TX_RD_ADDR=1 gives 0x22. Write 0x23=0x77 -> CMD_VALID pulse, CMD=77.
- Assert RESET_N=0 during ACCESS of a write to 0x12 -> ALERT_MASK=7FFF, ACK=0, FSM in IDLE. Read 0xFF -> 0 with ACK.
